// File: rtl/data_memory_pkg.sv
// Shared constants for the data memory: word width and the power-on data image
// that programs expect to find at the bottom of the address space.
package data_memory_pkg;

    localparam int WORD_W     = 32;
    localparam int INIT_WORDS = 6;

    localparam logic [WORD_W-1:0] INIT_IMAGE [INIT_WORDS] = '{
        32'd4, 32'd6, 32'd8, 32'd55, 32'd133, 32'd255
    };

endpackage

// File: rtl/dmem_reset_image.sv
// Maps a word index to its reset value; words beyond the initial image reset to zero.
module dmem_reset_image
    import data_memory_pkg::*;
#(
    parameter int IDX_W = 9
) (
    input  logic [IDX_W-1:0]  word_idx_i,
    output logic [WORD_W-1:0] reset_word_o
);

    always_comb begin
        reset_word_o = '0;
        for (int i = 0; i < INIT_WORDS; i++) begin
            if (word_idx_i == IDX_W'(i)) begin
                reset_word_o = INIT_IMAGE[i];
            end
        end
    end

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory: combinational read, full-word write on clk, async reset to a fixed image.
// Define DMEM_BOUNDS_CHECK_EN to make out-of-range word indices read 0 and drop writes instead of wrapping.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int N = 10,
    parameter int M = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      address_i,
    input  logic [WORD_W-1:0] write_data_i,
    input  logic              write_en_i,
    output logic [WORD_W-1:0] read_data_o
);

    localparam int WORDS = M / 4;
    // One extra bit so WORDS itself is representable when M == 2^N.
    localparam int IDX_W = N - 1;

    logic [IDX_W-1:0]  word_idx;
    logic [WORD_W-1:0] mem_words [WORDS];
    logic [WORD_W-1:0] read_word;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^address_i[1:0];

`ifdef DMEM_BOUNDS_CHECK_EN
    // Indices past the array match no word: reads fall through to 0, writes hit nothing.
    assign word_idx = {1'b0, address_i[N-1:2]};
`else
    localparam logic [IDX_W-1:0] WORDS_V = IDX_W'(WORDS);
    assign word_idx = {1'b0, address_i[N-1:2]} % WORDS_V;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_word
            logic [WORD_W-1:0] word_q;
            logic [WORD_W-1:0] reset_word;

            dmem_reset_image #(
                .IDX_W (IDX_W)
            ) u_reset_image (
                .word_idx_i   (IDX_W'(gi)),
                .reset_word_o (reset_word)
            );

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word_q <= reset_word;
                end else if (write_en_i && (word_idx == IDX_W'(gi))) begin
                    word_q <= write_data_i;
                end
            end

            assign mem_words[gi] = word_q;
        end
    endgenerate

    always_comb begin
        read_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (word_idx == IDX_W'(i)) begin
                read_word = mem_words[i];
            end
        end
    end

    assign read_data_o = read_word;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: reset image, aliasing, writes, write-enable gating and async reset.
module tb_data_memory;

    logic        clk;
    logic        rst;
    logic [9:0]  address_i;
    logic [31:0] write_data_i;
    logic        write_en_i;
    logic [31:0] read_data_o;

    int pass_cnt;
    int total_cnt;

    data_memory #(
        .N (10),
        .M (1024)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .address_i    (address_i),
        .write_data_i (write_data_i),
        .write_en_i   (write_en_i),
        .read_data_o  (read_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_cnt++;
        assert (observed === expected) begin
            pass_cnt++;
            $display("check %-14s addr=%0d observed=0x%08h expected=0x%08h", tag, address_i, observed, expected);
        end else begin
            $error("FAIL %s addr=%0d observed=0x%08h expected=0x%08h", tag, address_i, observed, expected);
        end
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        rst          = 1'b1;
        address_i    = 10'd0;
        write_data_i = 32'd0;
        write_en_i   = 1'b0;

        #1;
        check("rst_state", read_data_o, 32'd4);

        @(negedge clk);
        rst = 1'b0;

        // Reset image, read combinationally with no clock edge needed.
        address_i = 10'd0;  #1; check("img_w0", read_data_o, 32'd4);
        address_i = 10'd4;  #1; check("img_w1", read_data_o, 32'd6);
        address_i = 10'd8;  #1; check("img_w2", read_data_o, 32'd8);
        address_i = 10'd12; #1; check("img_w3", read_data_o, 32'd55);
        address_i = 10'd16; #1; check("img_w4", read_data_o, 32'd133);
        address_i = 10'd20; #1; check("img_w5", read_data_o, 32'd255);

        @(negedge clk);
        address_i = 10'd24;   #1; check("img_w6_zero", read_data_o, 32'd0);
        address_i = 10'd1020; #1; check("img_top_zero", read_data_o, 32'd0);
        address_i = 10'd1;    #1; check("alias_a1", read_data_o, 32'd4);

        @(negedge clk);
        address_i = 10'd2; #1; check("alias_a2", read_data_o, 32'd4);
        address_i = 10'd3; #1; check("alias_a3", read_data_o, 32'd4);

        // Write 100 to word 0: old value visible before the edge, new after.
        @(negedge clk);
        address_i    = 10'd0;
        write_data_i = 32'd100;
        write_en_i   = 1'b1;
        #1; check("wr_before_edge", read_data_o, 32'd4);
        @(posedge clk);
        #1; check("wr_after_edge", read_data_o, 32'd100);
        write_en_i = 1'b0;

        // Disabled write across two edges leaves word 2 alone.
        @(negedge clk);
        address_i    = 10'd8;
        write_data_i = 32'hDEADBEEF;
        write_en_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1; check("we0_no_write", read_data_o, 32'd8);

        // Misaligned write lands in the aligned word; top word is writable.
        @(negedge clk);
        address_i    = 10'd7;
        write_data_i = 32'h0000_1234;
        write_en_i   = 1'b1;
        @(posedge clk);
        #1;
        address_i = 10'd4; #1; check("misalign_wr", read_data_o, 32'h0000_1234);
        @(negedge clk);
        address_i    = 10'd1020;
        write_data_i = 32'hCAFE_F00D;
        @(posedge clk);
        #1; check("top_wr", read_data_o, 32'hCAFE_F00D);
        write_en_i = 1'b0;
        address_i  = 10'd1023; #1; check("top_alias", read_data_o, 32'hCAFE_F00D);
        address_i  = 10'd0;    #1; check("w0_intact", read_data_o, 32'd100);

        // Mid-cycle reset restores the image immediately, no clock edge.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1; check("async_rst_w0", read_data_o, 32'd4);
        address_i = 10'd1020; #1; check("async_rst_top", read_data_o, 32'd0);

        // Reset beats a simultaneous write.
        @(negedge clk);
        address_i    = 10'd4;
        write_data_i = 32'd77;
        write_en_i   = 1'b1;
        @(posedge clk);
        #1; check("rst_hold_w1", read_data_o, 32'd6);
        @(negedge clk);
        write_en_i = 1'b0;
        rst        = 1'b0;
        #1; check("rst_wins_w1", read_data_o, 32'd6);

        // Writes resume on the first edge after reset release.
        @(negedge clk);
        address_i    = 10'd12;
        write_data_i = 32'd9;
        write_en_i   = 1'b1;
        @(posedge clk);
        #1; check("post_rst_wr", read_data_o, 32'd9);
        write_en_i = 1'b0;
        address_i  = 10'd16; #1; check("post_rst_w4", read_data_o, 32'd133);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/data_memory.md
# data_memory

Word-organised data memory for the pipelined RISC core's memory stage. Holds M bytes as 32-bit words, with a byte address from the ALU. Reads are combinational; writes occur on the rising clock edge. Reset loads a fixed initial data image so programs start from known data.

## Interface
- N, default 10: byte-address width in bits.
- M, default 1024: memory size in bytes; must be a multiple of 4. Word count is M/4 (256 by default).
- clk  input  1: the single clock; all writes happen on its rising edge.
- rst  input  1: asynchronous, active-high reset. One clock, with reset asynchronous and active-high.
- address_i  input  N: byte address. Word index is address_i[N-1:2]; bits [1:0] are ignored.
- write_data_i  input  32: word to store.
- write_en_i  input  1: write strobe, active-high.
- read_data_o  output  32: word at the current word index.

## Operation
- Storage is an array of M/4 32-bit words.
- Read is combinational: read_data_o = mem[address_i[N-1:2]]. No clock, no enable, no latency.
- Write: on a rising clk edge with write_en_i=1 and rst=0, mem[address_i[N-1:2]] <= write_data_i. Full word only; there are no byte enables.
- Reset image: while rst=1, the whole array is forced to the image below, asynchronously.
  - Word 0 (byte 0) = 4
  - Word 1 (byte 4) = 6
  - Word 2 (byte 8) = 8
  - Word 3 (byte 12) = 55
  - Word 4 (byte 16) = 133
  - Word 5 (byte 20) = 255
  - All other words = 0
- Reset value of read_data_o is the image word at the current address, e.g. 4 at address 0.
- Misaligned address: low two bits are ignored, so addresses 1, 2 and 3 alias word 0.
- Reset and write at the same edge: reset wins and the write is discarded.
- Reset asserted mid-sequence: all earlier writes are lost and the image is restored.
- write_en_i undriven (X) is not a legal operating condition. Benches must drive it to 0 when idle.

## Timing
- Read latency is 0 cycles. read_data_o follows address_i and memory contents combinationally.
- Write latency is 1 edge. At the edge, the new value appears on read_data_o when address_i points at the written word.
- Read during write to the same word: the old value is visible before the edge and the new value after it. No bypass of write_data_i.
- Reset asserts asynchronously and takes effect immediately. Writes resume on the first rising edge after rst falls.

## Configuration
- DMEM_BOUNDS_CHECK_EN
  - Defined: word indices ≥ M/4, possible when 2^N > M, read as 0 and writes to them are ignored.
  - Undefined: the index wraps modulo M/4. A write always lands in the array and a read always returns an array word.
  - With default parameters (2^N = M), behaviour is identical either way.

## Structure
- Package data_memory_pkg holds:
  - WORD_W = 32
  - INIT_WORDS = 6
  - The initial-image constant array {4, 6, 8, 55, 133, 255}
- Sub-module dmem_reset_image: combinational, maps word index → reset value from the package constant. Used by the reset branch.

## Test plan
- Reset pulse, then read byte addresses 0, 4, 8, 12, 16, 20 → read_data_o = 4, 6, 8, 55, 133, 255, each within 2 time units with no clock edge.
- Read addresses 24 and 1020 after reset → 0. Read addresses 1, 2, 3 → 4 (alias of word 0).
- address_i=0, write_data_i=100, write_en_i=1, one rising edge → read_data_o=100. Before the edge it still reads 4.
- Write 0xDEADBEEF to address 8 with write_en_i=0 across two edges → address 8 still reads 8.
- Write 100 to address 0, then assert rst mid-cycle → read_data_o returns to 4 immediately, without waiting for a clock edge.
- Hold rst=1 and write_en_i=1 across an edge writing 77 to address 4 → address 4 reads 6 after reset is released.
